expr_checker: RTL and testbench
===============================

EXPR_CHECKER -- requirements
Module: expr_checker

Interface
REQ-001 Parameter: LEN_W, default 8, width of the accepted-character counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  in_char is presented this cycle.
REQ-005 in_char  input  8  ASCII character.
REQ-006 out  output  1  high while the characters accepted so far form a legal expression.
REQ-007 err  output  1  high once an illegal character sequence has been seen.
REQ-008 len  output  LEN_W  count of characters accepted since reset, saturating.

Function
REQ-009 Character classes SHALL be: DIGIT = 0x30-0x39; OP = 0x2B ('+') or 0x2A ('*'); OTHER = everything else.
REQ-010 The legal grammar SHALL be DIGIT (OP DIGIT)*, single-digit operands only.
REQ-011 The FSM SHALL have four states: S_IDLE (empty), S_NUM (last char digit), S_OP (last char operator), S_ERR.
REQ-012 Transitions on an accepted character: S_IDLE->S_NUM on DIGIT, else S_ERR; S_NUM->S_OP on OP, else S_ERR; S_OP->S_NUM on DIGIT, else S_ERR; S_ERR->S_ERR on any class.
REQ-013 A character SHALL be accepted only on a rising edge with in_valid=1; with in_valid=0 the state, len and outputs SHALL hold.
REQ-014 out SHALL be a registered Moore output: 1 iff state is S_NUM, visible the cycle after the accepting edge.
REQ-015 err SHALL be 1 iff state is S_ERR, also Moore.
REQ-016 len SHALL increment by 1 on every accepted character, in every state including S_ERR, and SHALL saturate at 2^LEN_W-1 without wrapping.
REQ-017 out and err SHALL never both be 1.

Reset
REQ-018 With reset=1 on a rising edge: state SHALL become S_IDLE, out=0, err=0, len=0.
REQ-019 reset SHALL take priority over a simultaneous in_valid=1; that character SHALL be discarded.
REQ-020 reset asserted mid-expression SHALL abandon it completely; no state survives.

Configuration
REQ-021 Macro EXPR_CLEAR_EN: when defined, an accepted 'C' (0x43) in any state SHALL move to S_IDLE and clear len to 0 on the same edge, without being counted.
REQ-022 Without EXPR_CLEAR_EN, 0x43 SHALL be class OTHER, and S_ERR SHALL be left only by reset.

Structure
REQ-023 State encodings, ASCII constants (0x30, 0x39, 0x2A, 0x2B, 0x43) and class codes SHALL live in the shared header/package expr_pkg.
REQ-024 One combinational sub-module, char_class, SHALL map in_char to a 2-bit class code; the FSM, counter and output registers SHALL be in expr_checker.

Verification
REQ-025 Reset, then accept "1","+","2","*","3" on consecutive cycles -> out after each edge 1,0,1,0,1; err=0; final len=5.
REQ-026 Accept "1","2" -> after "2": out=0, err=1, len=2; then "+","3" -> err stays 1, len=4.
REQ-027 Accept "1", then hold in_valid=0 for 3 cycles with in_char=0x2B toggling -> out stays 1, len stays 1.
REQ-028 Accept "+" first -> err=1, out=0; assert reset together with in_valid=1 and in_char "5" -> next cycle out=0, err=0, len=0.
REQ-029 With LEN_W=2, accept "1+1+1+1" (7 characters) -> len reads 1,2,3,3,3,3,3; out=1 at the end.
REQ-030 With EXPR_CLEAR_EN, accept "+" then "C" then "7" -> err=1, then S_IDLE (out=0, err=0, len=0), then out=1, len=1; without the macro the same sequence -> err stays 1 and len=3.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared definitions for the expression checker: FSM states, character
// classes and the ASCII constants the classifier matches against.
package expr_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OP   = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_OP    = 2'd1,
    CLS_OTHER = 2'd2,
    CLS_CLEAR = 2'd3
  } cls_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_CLEAR = 8'h43;

endpackage

// File: rtl/expr_checker_char_class.sv
// Combinational character classifier. With EXPR_CLEAR_EN defined, 'C' maps
// to its own clear class; otherwise it is just OTHER.
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] i_char,
  output cls_t       o_cls
);

  always_comb begin
    o_cls = CLS_OTHER;
    if (i_char >= CH_0 && i_char <= CH_9) begin
      o_cls = CLS_DIGIT;
    end else if (i_char == CH_PLUS || i_char == CH_STAR) begin
      o_cls = CLS_OP;
    end
`ifdef EXPR_CLEAR_EN
    else if (i_char == CH_CLEAR) begin
      o_cls = CLS_CLEAR;
    end
`endif
  end

endmodule

// File: rtl/expr_checker.sv
// Streaming checker for the grammar DIGIT (OP DIGIT)* with a saturating
// accepted-character counter. Optional feature macro: EXPR_CLEAR_EN.
//
// Handshake: a character is consumed on a rising edge iff in_valid=1 and
// reset=0; there is no back-pressure, every valid character is taken.
module expr_checker
  import expr_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             out,
  output logic             err,
  output logic [LEN_W-1:0] len,
  output state_t           dbg_state
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  cls_t             w_cls;
  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_next_len;
  logic             r_out;
  logic             r_err;

  char_class u_char_class (
    .i_char (in_char),
    .o_cls  (w_cls)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_len   = r_len;
    if (in_valid) begin
      case (r_state)
        S_IDLE:  w_next_state = (w_cls == CLS_DIGIT) ? S_NUM : S_ERR;
        S_NUM:   w_next_state = (w_cls == CLS_OP)    ? S_OP  : S_ERR;
        S_OP:    w_next_state = (w_cls == CLS_DIGIT) ? S_NUM : S_ERR;
        default: w_next_state = S_ERR;
      endcase
      if (r_len != LEN_MAX) begin
        w_next_len = r_len + 1'b1;
      end
`ifdef EXPR_CLEAR_EN
      // Clear overrides both the transition and the count of this character.
      if (w_cls == CLS_CLEAR) begin
        w_next_state = S_IDLE;
        w_next_len   = '0;
      end
`endif
    end
  end

  // Outputs are decoded from the next state so they are true flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_out   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_len   <= w_next_len;
      r_out   <= (w_next_state == S_NUM);
      r_err   <= (w_next_state == S_ERR);
    end
  end

  assign out       = r_out;
  assign err       = r_err;
  assign len       = r_len;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_expr_checker.sv
// Self-checking bench for expr_checker: two instances (LEN_W=8 and LEN_W=2)
// share one stimulus stream and are compared against a string-based model.
module tb_expr_checker;
  import expr_pkg::*;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_char;

  logic         out8, err8, out2, err2;
  logic [7:0]   len8;
  logic [1:0]   len2;
  state_t       st8, st2;

  int n_checks = 0;
  int n_fail   = 0;

  // Characters accepted since the last reset/clear, in order.
  logic [7:0] exp_q[$];

  expr_checker #(.LEN_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .out(out8), .err(err8), .len(len8), .dbg_state(st8)
  );

  expr_checker #(.LEN_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_char(in_char),
    .out(out2), .err(err2), .len(len2), .dbg_state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_op(input logic [7:0] c);
    return (c == 8'h2B) || (c == 8'h2A);
  endfunction

  // Illegal once any character fails to match digit-at-even / op-at-odd.
  function automatic bit m_err();
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((i % 2 == 0) && !is_digit(exp_q[i])) return 1'b1;
      if ((i % 2 == 1) && !is_op(exp_q[i]))    return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_out();
    return !m_err() && (exp_q.size() % 2 == 1);
  endfunction

  function automatic int m_len(input int w);
    int mx;
    mx = (1 << w) - 1;
    return (exp_q.size() > mx) ? mx : exp_q.size();
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [7:0] c, input logic rst);
    @(negedge clk);
    reset    = rst;
    in_valid = v;
    in_char  = c;
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
    end else if (v) begin
`ifdef EXPR_CLEAR_EN
      if (c == 8'h43) exp_q.delete();
      else            exp_q.push_back(c);
`else
      exp_q.push_back(c);
`endif
    end
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    n_checks++; if (out8 !== 1'b0) begin n_fail++; $display("FAIL reset_out got %b want 0", out8); end
    n_checks++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err8); end
    n_checks++; if (len8 !== 8'd0) begin n_fail++; $display("FAIL reset_len got %0d want 0", len8); end
    n_checks++; if (st8 !== S_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", st8, S_IDLE); end
  endtask

  task automatic test_legal();
    string s;
    logic [4:0] want_out;
    s = "1+2*3";
    want_out = 5'b10101;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, s[i], 1'b0);
      n_checks++; if (out8 !== want_out[4-i]) begin n_fail++; $display("FAIL legal_out step %0d got %b want %b", i, out8, want_out[4-i]); end
      n_checks++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL legal_err step %0d got %b want 0", i, err8); end
    end
    n_checks++; if (len8 !== 8'd5) begin n_fail++; $display("FAIL legal_len got %0d want 5", len8); end
  endtask

  task automatic test_error();
    string s;
    s = "12+3";
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, s[0], 1'b0);
    drive(1'b1, s[1], 1'b0);
    n_checks++; if (out8 !== 1'b0) begin n_fail++; $display("FAIL err_out got %b want 0", out8); end
    n_checks++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL err_err got %b want 1", err8); end
    n_checks++; if (len8 !== 8'd2) begin n_fail++; $display("FAIL err_len2 got %0d want 2", len8); end
    drive(1'b1, s[2], 1'b0);
    drive(1'b1, s[3], 1'b0);
    n_checks++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err8); end
    n_checks++; if (len8 !== 8'd4) begin n_fail++; $display("FAIL err_len4 got %0d want 4", len8); end
  endtask

  task automatic test_hold();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h31, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, (i % 2 == 0) ? 8'h2B : 8'h58, 1'b0);
      n_checks++; if (out8 !== 1'b1) begin n_fail++; $display("FAIL hold_out cycle %0d got %b want 1", i, out8); end
      n_checks++; if (len8 !== 8'd1) begin n_fail++; $display("FAIL hold_len cycle %0d got %0d want 1", i, len8); end
    end
  endtask

  task automatic test_reset_priority();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h2B, 1'b0);
    n_checks++; if (err8 !== 1'b1 || out8 !== 1'b0) begin n_fail++; $display("FAIL rp_first got out=%b err=%b want out=0 err=1", out8, err8); end
    drive(1'b1, 8'h35, 1'b1);
    n_checks++; if (out8 !== 1'b0) begin n_fail++; $display("FAIL rp_out got %b want 0", out8); end
    n_checks++; if (err8 !== 1'b0) begin n_fail++; $display("FAIL rp_err got %b want 0", err8); end
    n_checks++; if (len8 !== 8'd0) begin n_fail++; $display("FAIL rp_len got %0d want 0", len8); end
  endtask

  task automatic test_saturate();
    string s;
    logic [1:0] want[7];
    s = "1+1+1+1";
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, s[i], 1'b0);
      n_checks++; if (len2 !== want[i]) begin n_fail++; $display("FAIL sat_len step %0d got %0d want %0d", i, len2, want[i]); end
    end
    n_checks++; if (out2 !== 1'b1) begin n_fail++; $display("FAIL sat_out got %b want 1", out2); end
    n_checks++; if (len8 !== 8'd7) begin n_fail++; $display("FAIL sat_len8 got %0d want 7", len8); end
  endtask

  task automatic test_clear();
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h2B, 1'b0);
    n_checks++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL clr_plus_err got %b want 1", err8); end
    drive(1'b1, 8'h43, 1'b0);
`ifdef EXPR_CLEAR_EN
    n_checks++; if (out8 !== 1'b0 || err8 !== 1'b0 || len8 !== 8'd0) begin n_fail++; $display("FAIL clr_c got out=%b err=%b len=%0d want 0/0/0", out8, err8, len8); end
    drive(1'b1, 8'h37, 1'b0);
    n_checks++; if (out8 !== 1'b1 || len8 !== 8'd1) begin n_fail++; $display("FAIL clr_7 got out=%b len=%0d want 1/1", out8, len8); end
`else
    n_checks++; if (err8 !== 1'b1) begin n_fail++; $display("FAIL clr_c_err got %b want 1", err8); end
    drive(1'b1, 8'h37, 1'b0);
    n_checks++; if (err8 !== 1'b1 || len8 !== 8'd3) begin n_fail++; $display("FAIL clr_7 got err=%b len=%0d want 1/3", err8, len8); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic       v, r;
    int         k;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5)       c = 8'h30 + 8'($urandom_range(0, 9));
      else if (k == 5) c = 8'h2B;
      else if (k == 6) c = 8'h2A;
      else if (k == 7) c = 8'h43;
      else             c = 8'($urandom_range(0, 255));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 24) == 0);
      drive(v, c, r);
      n_checks++; if (out8 !== m_out()) begin n_fail++; $display("FAIL rnd_out8 step %0d got %b want %b", i, out8, m_out()); end
      n_checks++; if (err8 !== m_err()) begin n_fail++; $display("FAIL rnd_err8 step %0d got %b want %b", i, err8, m_err()); end
      n_checks++; if (len8 !== 8'(m_len(8))) begin n_fail++; $display("FAIL rnd_len8 step %0d got %0d want %0d", i, len8, m_len(8)); end
      n_checks++; if (len2 !== 2'(m_len(2))) begin n_fail++; $display("FAIL rnd_len2 step %0d got %0d want %0d", i, len2, m_len(2)); end
      n_checks++; if (out2 !== m_out() || err2 !== m_err()) begin n_fail++; $display("FAIL rnd_flags2 step %0d got out=%b err=%b want %b/%b", i, out2, err2, m_out(), m_err()); end
      n_checks++; if (out8 === 1'b1 && err8 === 1'b1) begin n_fail++; $display("FAIL rnd_exclusive step %0d got out=1 err=1 want not both", i); end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    test_reset();
    test_legal();
    test_error();
    test_hold();
    test_reset_priority();
    test_saturate();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
